load_store_unit: RTL and testbench

//  Executes RV32I loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a req/ack data bus.

---
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a req/ack bus; define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
// state | meaning:  IDLE wait for start | REQ bus request until ack/timeout | WB one-cycle done + rf write
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic                    is_load,
  input  logic [2:0]              funct3,
  input  logic [31:0]             addr,
  input  logic [31:0]             store_data,
  input  logic [4:0]              rd_in,
  load_store_unit_if.master       bus,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic                    rf_write,
  output logic [4:0]              rf_rd,
  output logic [31:0]             rf_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;

  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  state_t      state, state_next;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] sd_q;
  logic [4:0]  rd_q;
  logic [31:0] cnt;
  logic        fault_q;

  logic        legal_f3, access_ok, capture, timed_out;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, rdata_shift, load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    if (is_load) legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
    else         legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
`ifdef MISALIGN_TRAP_EN
    access_ok = legal_f3 &&
                !((funct3[1:0] == 2'b01) && addr[0]) &&
                !((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    access_ok = legal_f3;
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        capture    = 1'b1;
        state_next = access_ok ? S_REQ : S_WB;
      end
      S_REQ: begin
        if (bus.bus_ack) state_next = S_WB;
        else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
          timed_out  = 1'b1;
          state_next = S_WB;
        end
      end
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Store lane placement: replicated data, enables pick the lane(s).
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{sd_q[7:0]}};
      end
      2'b01: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{sd_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = sd_q;
      end
    endcase
  end

  always_comb begin
    rdata_shift = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    ld_byte     = rdata_shift[7:0];
    ld_half     = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      is_load_q <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 32'd0;
      sd_q      <= 32'd0;
      rd_q      <= 5'd0;
      cnt       <= 32'd0;
      fault_q   <= 1'b0;
      rf_rd     <= 5'd0;
      rf_wdata  <= 32'd0;
    end else begin
      if (capture) begin
        is_load_q <= is_load;
        funct3_q  <= funct3;
        addr_q    <= addr;
        sd_q      <= store_data;
        rd_q      <= rd_in;
        cnt       <= 32'd0;
        fault_q   <= !access_ok;
        if (!access_ok) begin
          rf_rd    <= rd_in;
          rf_wdata <= 32'd0;
        end
      end
      if (state == S_REQ) begin
        if (bus.bus_ack) begin
          rf_rd    <= rd_q;
          rf_wdata <= is_load_q ? load_val : 32'd0;
        end else if (timed_out) begin
          fault_q  <= 1'b1;
          rf_rd    <= rd_q;
          rf_wdata <= 32'd0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

  assign bus.bus_req   = (state == S_REQ);
  assign bus.bus_we    = bus.bus_req & ~is_load_q;
  assign bus.bus_addr  = bus.bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.bus_be    = bus.bus_req ? st_be : 4'd0;
  assign bus.bus_wdata = (bus.bus_req && !is_load_q) ? st_wdata : 32'd0;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_WB);
  assign fault    = done & fault_q;
  assign rf_write = done & is_load_q & ~fault_q & (rf_rd != 5'd0);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES=4); honours MISALIGN_TRAP_EN.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        nrst;
  logic        start, is_load;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        busy, done, fault, rf_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst), .start(start), .is_load(is_load), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd_in(rd_in), .bus(bus),
    .busy(busy), .done(done), .fault(fault), .rf_write(rf_write),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the following cycle.
  task automatic launch(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd);
    start = 1'b1; is_load = ld; funct3 = f3; addr = a; store_data = sd; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rdata);
    bus.bus_ack = 1'b1; bus.bus_rdata = rdata;
    @(negedge clk);
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
  endtask

  initial begin
    int n;
    nrst = 1'b0; start = 1'b0; is_load = 1'b0; funct3 = 3'b000;
    addr = 32'd0; store_data = 32'd0; rd_in = 5'd0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {bus.bus_req, bus.bus_we, done, fault, rf_write}, 0);
    chk("rst_rf", {rf_rd, rf_wdata}, 0);
    chk("rst_bus", bus.bus_addr | bus.bus_wdata | bus.bus_be, 0);
    nrst = 1'b1;
    @(negedge clk);

    // SW 0x100, ack after three request cycles
    launch(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3);
    chk("sw_req", {bus.bus_req, bus.bus_we, busy}, 3'b111);
    chk("sw_addr", bus.bus_addr, 32'h100);
    chk("sw_be", bus.bus_be, 4'b1111);
    chk("sw_wdata", bus.bus_wdata, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    chk("sw_hold", {bus.bus_req, done}, 2'b10);
    ack_now(32'h0);
    chk("sw_done", {done, fault, rf_write, bus.bus_req}, 4'b1000);
    chk("sw_rfw", rf_wdata, 0);
    @(negedge clk);
    chk("sw_idle", {busy, done}, 0);

    // LB 0x103 with zero-wait ack: done in cycle 2
    launch(1'b1, 3'b000, 32'h103, 32'h0, 5'd5);
    chk("lb_bus", {bus.bus_req, bus.bus_we}, 2'b10);
    chk("lb_addr", bus.bus_addr, 32'h100);
    ack_now(32'h80FF_0000);
    chk("lb_done", {done, fault, rf_write}, 3'b101);
    chk("lb_rd", rf_rd, 5);
    chk("lb_data", rf_wdata, 32'hFFFF_FF80);
    @(negedge clk);
    chk("lb_hold", rf_wdata, 32'hFFFF_FF80);
    chk("lb_wr_off", {rf_write, done}, 0);

    // LHU / LH upper half
    launch(1'b1, 3'b101, 32'h102, 32'h0, 5'd7);
    ack_now(32'h8001_1234);
    chk("lhu_data", rf_wdata, 32'h0000_8001);
    chk("lhu_wr", rf_write, 1);
    @(negedge clk);
    launch(1'b1, 3'b001, 32'h100, 32'h0, 5'd7);
    ack_now(32'h8001_9234);
    chk("lh_data", rf_wdata, 32'hFFFF_9234);
    @(negedge clk);
    // LBU lane 1
    launch(1'b1, 3'b100, 32'h101, 32'h0, 5'd8);
    ack_now(32'h1122_F344);
    chk("lbu_data", rf_wdata, 32'h0000_00F3);
    @(negedge clk);

    // LW to x0: data returned but no write
    launch(1'b1, 3'b010, 32'h200, 32'h0, 5'd0);
    ack_now(32'h1234_5678);
    chk("lw0_done", {done, fault, rf_write}, 3'b100);
    chk("lw0_data", rf_wdata, 32'h1234_5678);
    @(negedge clk);

    // SB 0x201, a second start during REQ must be ignored
    launch(1'b0, 3'b000, 32'h201, 32'h0000_00AB, 5'd0);
    chk("sb_be", bus.bus_be, 4'b0010);
    chk("sb_wdata", bus.bus_wdata, 32'hABABABAB);
    start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h300; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    chk("sb_ign_addr", bus.bus_addr, 32'h200);
    chk("sb_ign_we", bus.bus_we, 1);
    ack_now(32'hFFFF_FFFF);
    chk("sb_done", {done, fault, rf_write}, 3'b100);
    chk("sb_rfw", rf_wdata, 0);
    @(negedge clk);
    chk("sb_idle", busy, 0);

    // SH 0x203: upper half lane regardless of addr[0] when no trap
`ifndef MISALIGN_TRAP_EN
    launch(1'b0, 3'b001, 32'h203, 32'h0000_1234, 5'd0);
    chk("sh_be", bus.bus_be, 4'b1100);
    chk("sh_wdata", bus.bus_wdata, 32'h1234_1234);
    ack_now(32'h0);
    @(negedge clk);
`endif

    // Illegal funct3: straight to WB with fault, no bus cycle
    launch(1'b1, 3'b011, 32'h100, 32'h0, 5'd4);
    chk("ill_ld", {bus.bus_req, done, fault, rf_write}, 4'b0110);
    chk("ill_ld_rf", {rf_rd, rf_wdata}, {5'd4, 32'd0});
    @(negedge clk);
    launch(1'b0, 3'b100, 32'h100, 32'h0, 5'd0);
    chk("ill_st", {bus.bus_req, done, fault}, 3'b011);
    @(negedge clk);

    // Timeout: four request cycles, then faulted done
    launch(1'b1, 3'b010, 32'h400, 32'h0, 5'd6);
    n = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.bus_req) n++;
      @(negedge clk);
    end
    chk("to_done", done, 1);
    chk("to_cycles", n, 4);
    chk("to_flags", {bus.bus_req, fault, rf_write}, 3'b010);
    chk("to_rfw", rf_wdata, 0);
    @(negedge clk);

    // Reset mid-REQ: immediate abort, no done afterwards
    launch(1'b0, 3'b010, 32'h500, 32'h5555_AAAA, 5'd0);
    chk("rst_mid_req", bus.bus_req, 1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_abort", {bus.bus_req, busy}, 0);
    @(negedge clk);
    nrst = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("rst_mid_nodone", n, 0);

    // Misaligned LW 0x102
    launch(1'b1, 3'b010, 32'h102, 32'h0, 5'd10);
`ifdef MISALIGN_TRAP_EN
    chk("mis_noreq", bus.bus_req, 0);
    chk("mis_fault", {done, fault, rf_write}, 3'b110);
    @(negedge clk);
    launch(1'b0, 3'b001, 32'h101, 32'h0, 5'd0);
    chk("mis_sh", {bus.bus_req, done, fault}, 3'b011);
`else
    chk("mis_addr", bus.bus_addr, 32'h100);
    ack_now(32'hCAFE_F00D);
    chk("mis_nofault", {done, fault, rf_write}, 3'b101);
    chk("mis_data", rf_wdata, 32'hCAFE_F00D);
`endif
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
